// File: rtl/apb_master_bridge.sv
`timescale 1ns/1ps
// apb_master_bridge
//
// Turns a valid/ready request channel into APB3 SETUP/ACCESS transfers and
// returns the read data and the error status on a valid/ready response
// channel. At most one transfer is in flight. A new request is refused while
// a response is waiting to be taken. An optional PREADY wait-state timeout
// aborts an ACCESS phase that a slave never completes.
//
// Ports
//   pclk, rst                 clock; synchronous active-high reset
//   req_valid/req_ready       request handshake (req_ready is combinational)
//   req_write/addr/wdata      request fields
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata/err/timeout     response fields, held until taken
//   psel..pwdata              APB requester outputs
//   prdata/pready/pslverr     APB completer inputs
//
// Parameters
//   ADDR_WIDTH, DATA_WIDTH    bus widths
//   TIMEOUT                   maximum ACCESS cycles before abort; 0 = wait forever

module apb_master_bridge #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  rst,
  // request channel
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB bus
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TimeoutEn = (TIMEOUT != 0);
  // Count value seen on the last permitted ACCESS cycle.
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  // Only accept when idle and the previous response has been consumed.
  assign req_ready = !rst && (state_q == StIdle) && !rsp_valid_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    // Response fields stay as they are; only the valid flag drops.
    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          state_d   = StSetup;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = req_addr;
          pwrite_d  = req_write;
          pwdata_d  = req_write ? req_wdata : '0;
        end
      end

      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
        cnt_d     = '0;
      end

      StAccess: begin
        if (pready) begin
          state_d       = StIdle;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
        end else if (TimeoutEn && (cnt_q == CntLast)) begin
          state_d       = StIdle;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else if (cnt_q != {CntW{1'b1}}) begin
          // Saturate so an unlimited wait never wraps the count.
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = StIdle;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
